// File: rtl/fb_sram_arbiter.sv
// fb_sram_arbiter: single-SRAM double-buffered frame store arbiter (display reader vs drawer)
// Ports:
//   Clk, Reset                 clock and synchronous active-high reset
//   disp_req/addr/rdata/ack    display read port; addr is an offset in the front buffer
//   draw_req/we/addr/wdata     drawer read/write port; addr is an offset in the back buffer
//   draw_rdata/ack             drawer read data and completion pulse
//   swap_req/swap_done         buffer swap request pulse and toggle-done pulse
//   even_frame                 0: display buffer 0, draw buffer 1; 1: reversed
//   SRAM_*                     SRAM data bus, address and active-low strobes
module fb_sram_arbiter #(
    parameter int ACCESS_CYCLES  = 2,
    parameter int MAX_DISP_BURST = 4,
    parameter int OFFSET_W       = 19
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                disp_req,
    input  logic [OFFSET_W-1:0] disp_addr,
    output logic [15:0]         disp_rdata,
    output logic                disp_ack,
    input  logic                draw_req,
    input  logic                draw_we,
    input  logic [OFFSET_W-1:0] draw_addr,
    input  logic [15:0]         draw_wdata,
    output logic [15:0]         draw_rdata,
    output logic                draw_ack,
    input  logic                swap_req,
    output logic                swap_done,
    output logic                even_frame,
    inout  wire  [15:0]         SRAM_DQ,
    output logic [OFFSET_W:0]   SRAM_ADDRESS,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N
);
    typedef enum logic [1:0] {IDLE, DISP_ACC, DRAW_ACC, TURN} state_t;

    localparam int CW = $clog2(ACCESS_CYCLES) + 1;
    localparam int SW = $clog2(MAX_DISP_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_DISP_BURST);

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          lat_we, swap_pending;
    logic [15:0]   lat_wdata;
    logic          last, access, drive, swap_now, disp_grant, draw_grant;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            streak       <= '0;
            lat_we       <= 1'b0;
            lat_wdata    <= '0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
            even_frame   <= 1'b0;
            disp_ack     <= 1'b0;
            draw_ack     <= 1'b0;
            disp_rdata   <= '0;
            draw_rdata   <= '0;
            SRAM_ADDRESS <= '0;
        end else begin
            state     <= next_state;
            cnt       <= (access && !last) ? cnt + 1'b1 : '0;
            disp_ack  <= state == DISP_ACC && last;
            draw_ack  <= state == DRAW_ACC && last;
            swap_done <= swap_now;
            if (state == DISP_ACC && last)
                disp_rdata <= SRAM_DQ;
            if (state == DRAW_ACC && last && !lat_we)
                draw_rdata <= SRAM_DQ;
            if (swap_now)
                even_frame <= ~even_frame;
            // a swap_req arriving while one is already pending merges into it
            swap_pending <= swap_now ? 1'b0 : (swap_pending | swap_req);
            if (disp_grant) begin
                SRAM_ADDRESS <= {even_frame, disp_addr};
                lat_we       <= 1'b0;
            end
            if (draw_grant) begin
                SRAM_ADDRESS <= {~even_frame, draw_addr};
                lat_we       <= draw_we;
                lat_wdata    <= draw_wdata;
            end
            // counts display grants taken while the drawer is kept waiting
            streak <= (draw_grant || !draw_req) ? '0 :
                      (disp_grant && streak != SMAX) ? streak + 1'b1 : streak;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (swap_pending)                      next_state = IDLE;
                else if (draw_req && streak == SMAX)   next_state = DRAW_ACC;
                else if (disp_req)                     next_state = DISP_ACC;
                else if (draw_req)                     next_state = DRAW_ACC;
            end
            DISP_ACC: if (last) next_state = IDLE;
            DRAW_ACC: if (last) next_state = lat_we ? TURN : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        last       = cnt == LAST;
        access     = state == DISP_ACC || state == DRAW_ACC;
        drive      = state == DRAW_ACC && lat_we;
        swap_now   = state == IDLE && swap_pending;
        disp_grant = state == IDLE && next_state == DISP_ACC;
        draw_grant = state == IDLE && next_state == DRAW_ACC;
        SRAM_CE_N  = !access;
        SRAM_OE_N  = !(access && !lat_we);
        SRAM_WE_N  = !drive;
    end

    assign SRAM_DQ = drive ? lat_wdata : 16'hzzzz;
endmodule

// File: tb/tb_fb_sram_arbiter.sv
// tb_fb_sram_arbiter: directed bench for fb_sram_arbiter with an SRAM model and ack scoreboard
module tb_fb_sram_arbiter;
    localparam int AC  = 2;
    localparam int MDB = 4;
    localparam int OW  = 19;

    typedef struct {
        logic        disp;
        logic [15:0] data;
    } exp_t;

    logic          Clk = 0, Reset = 1;
    logic          disp_req = 0, draw_req = 0, draw_we = 0, swap_req = 0;
    logic [OW-1:0] disp_addr = '0, draw_addr = '0;
    logic [15:0]   draw_wdata = '0;
    logic [15:0]   disp_rdata, draw_rdata;
    logic          disp_ack, draw_ack, swap_done, even_frame;
    logic [OW:0]   SRAM_ADDRESS;
    logic          SRAM_WE_N, SRAM_OE_N, SRAM_CE_N;
    wire  [15:0]   SRAM_DQ;

    logic          probe_en = 0;
    logic [15:0]   probe_val = '0;
    logic [15:0]   mem [0:1023];
    logic [1023:0] written = '0;
    logic [15:0]   shadow [logic [19:0]];
    exp_t          sb [$];
    int            checks = 0, failures = 0, acks_seen = 0;
    logic          exp_ef = 0;
    logic [15:0]   last_draw_rd = '0;
    logic          prev_da = 0, prev_wa = 0;

    fb_sram_arbiter #(.ACCESS_CYCLES(AC), .MAX_DISP_BURST(MDB), .OFFSET_W(OW)) dut (
        .Clk(Clk), .Reset(Reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_ack(disp_ack),
        .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
        .draw_rdata(draw_rdata), .draw_ack(draw_ack),
        .swap_req(swap_req), .swap_done(swap_done), .even_frame(even_frame),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDRESS(SRAM_ADDRESS),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N)
    );

    always #5 Clk = ~Clk;

    function automatic logic [9:0] idx(input logic [19:0] a);
        return {a[19], a[8:0]};
    endfunction

    function automatic logic [15:0] init_val(input logic [9:0] i);
        return {6'h2A, i} ^ 16'h0F0F;
    endfunction

    function automatic logic [15:0] exp_read(input logic [19:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(idx(a));
    endfunction

    // SRAM model: untouched words read back a fixed address-derived pattern
    wire        model_oe = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    wire [9:0]  cur_idx  = idx(SRAM_ADDRESS);
    wire [15:0] model_rd = written[cur_idx] ? mem[cur_idx] : init_val(cur_idx);
    assign SRAM_DQ = probe_en ? probe_val : model_oe ? model_rd : 16'hzzzz;

    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            mem[cur_idx]     <= SRAM_DQ;
            written[cur_idx] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // scoreboard: each ack pops the oldest expectation and checks source and data
    always @(negedge Clk) begin
        exp_t e;
        if (disp_ack || draw_ack) begin
            acks_seen++;
            if (sb.size() == 0)
                chk("unexpected_ack", {30'd0, disp_ack, draw_ack}, 32'd0);
            else begin
                e = sb.pop_front();
                chk("ack_src", {30'd0, disp_ack, draw_ack}, e.disp ? 32'd2 : 32'd1);
                chk("ack_rdata", e.disp ? disp_rdata : draw_rdata, e.data);
            end
            chk("ack_pulse", {30'd0, disp_ack & prev_da, draw_ack & prev_wa}, 32'd0);
        end
        prev_da = disp_ack;
        prev_wa = draw_ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic probe_dq(input string tag);
        probe_val = 16'h1248;
        probe_en  = 1;
        #1;
        chk(tag, SRAM_DQ, 16'h1248);
        probe_en  = 0;
    endtask

    function automatic exp_t mk_exp(input logic d, input logic we, input logic [19:0] ma, input logic [15:0] wd);
        exp_t e;
        e.disp = d;
        if (we) begin
            shadow[ma] = wd;
            e.data = last_draw_rd;
        end else begin
            e.data = exp_read(ma);
            if (!d) last_draw_rd = e.data;
        end
        return e;
    endfunction

    // single access from IDLE; request dropped one cycle after the grant edge
    task automatic do_req(input logic d, input logic we, input logic [OW-1:0] a, input logic [15:0] wd);
        logic [19:0] ma;
        int n;
        ma = d ? {exp_ef, a} : {~exp_ef, a};
        sb.push_back(mk_exp(d, we, ma, wd));
        if (d) begin
            disp_req = 1; disp_addr = a;
        end else begin
            draw_req = 1; draw_we = we; draw_addr = a; draw_wdata = wd;
        end
        tick();
        disp_req = 0; draw_req = 0; draw_we = 0;
        disp_addr = ~a; draw_addr = ~a; draw_wdata = ~wd;
        chk("acc_addr", SRAM_ADDRESS, ma);
        chk("acc_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, we ? 3'b010 : 3'b001);
        if (we) chk("acc_dq", SRAM_DQ, wd);
        n = 1;
        while (!(d ? disp_ack : draw_ack) && n < 10) begin
            tick();
            n++;
        end
        chk("ack_latency", n, AC + 1);
        if (we) begin
            chk("turn_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
            probe_dq("turn_dq_z");
        end
        tick();
    endtask

    initial begin
        exp_t e;
        int n;
        repeat (2) @(posedge Clk);
        tick();
        Reset = 0;
        chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        chk("rst_addr", SRAM_ADDRESS, 0);
        chk("rst_flags", {disp_ack, draw_ack, swap_done, even_frame}, 0);
        chk("rst_rdata", {disp_rdata, draw_rdata}, 0);
        probe_dq("rst_dq_z");

        // reset in the middle of a write abandons it without an ack
        draw_req = 1; draw_we = 1; draw_addr = 19'h33; draw_wdata = 16'hCAFE;
        tick();
        chk("midwrite_we", SRAM_WE_N, 0);
        Reset = 1; draw_req = 0; draw_we = 0;
        tick();
        tick();
        Reset = 0;
        chk("rst2_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        chk("rst2_ef", even_frame, 0);
        probe_dq("rst2_dq_z");
        repeat (6) tick();
        chk("no_ack_after_reset", acks_seen, 0);

        // write to back buffer then read front buffer at the same offset
        do_req(0, 1, 19'h10, 16'hBEEF);
        chk("idle_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        do_req(1, 0, 19'h10, 16'h0);

        // swap, then the written word becomes visible to the display
        swap_req = 1;
        tick();
        swap_req = 0;
        chk("swap_pending_ef", {even_frame, swap_done}, 2'b00);
        tick();
        chk("swap_ef", {even_frame, swap_done}, 2'b11);
        exp_ef = 1;
        tick();
        chk("swap_done_pulse", swap_done, 0);
        do_req(0, 1, 19'h5, 16'h1234);
        do_req(1, 0, 19'h5, 16'h0);

        // two swap requests around a write merge into one toggle after the ack
        sb.push_back(mk_exp(0, 1, {~exp_ef, 19'h40}, 16'h7777));
        draw_req = 1; draw_we = 1; draw_addr = 19'h40; draw_wdata = 16'h7777;
        tick();
        draw_req = 0; draw_we = 0;
        swap_req = 1;
        chk("sw_acc_we", SRAM_WE_N, 0);
        tick();
        swap_req = 0;
        chk("sw_ef_hold1", even_frame, 1);
        tick();
        swap_req = 1;
        disp_req = 1; disp_addr = 19'h40;
        sb.push_back(mk_exp(1, 0, {~exp_ef, 19'h40}, 16'h0));
        chk("sw_ef_hold2", even_frame, 1);
        tick();
        swap_req = 0;
        chk("sw_ef_hold3", {even_frame, SRAM_CE_N}, 2'b11);
        tick();
        chk("sw_toggle_nogrant", {even_frame, swap_done, SRAM_CE_N}, 3'b011);
        exp_ef = 0;
        tick();
        disp_req = 0;
        chk("sw_grant_after", {swap_done, SRAM_CE_N}, 2'b00);
        chk("sw_disp_addr", SRAM_ADDRESS, 20'h00040);
        n = 0;
        while (!disp_ack && n < 10) begin
            tick();
            n++;
        end
        chk("sw_disp_latency", n, AC);
        repeat (6) tick();
        chk("sw_single_toggle", even_frame, 0);

        // both requesters saturated: D,D,D,D,W repeating
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < MDB; k++) sb.push_back(mk_exp(1, 0, {exp_ef, 19'h20}, 16'h0));
            sb.push_back(mk_exp(0, 0, {~exp_ef, 19'h60}, 16'h0));
        end
        disp_req = 1; disp_addr = 19'h20;
        draw_req = 1; draw_we = 0; draw_addr = 19'h60;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge Clk);
            #1;
            n++;
        end
        disp_req = 0; draw_req = 0;
        chk("burst_drained", sb.size(), 0);
        repeat (3) tick();

        // lone display read of an unwritten word, request dropped after grant
        do_req(1, 0, 19'h77, 16'h0);
        repeat (3) tick();
        chk("sb_empty_end", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
